// File: rtl/tensor_operand_server.sv
// rtl/tensor_operand_server.sv - operand register file answering matmul engine reads, loaded by host bursts
module tensor_operand_server #(
  parameter int DATA1_LEN_BITS = 2,
  parameter int DATA2_ROW_BITS = 2,
  parameter int DATA2_COL_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      lock,
  input  logic                      load_start,
  input  logic                      load_target,
  input  logic                      load_valid,
  input  logic [15:0]               load_data,
  output logic                      load_ready,
  output logic                      load_done,
  output logic                      err_locked,
  input  logic [DATA1_LEN_BITS-1:0] sel_vec,
  input  logic [DATA2_ROW_BITS-1:0] sel_row,
  input  logic [DATA2_COL_BITS-1:0] sel_col,
  output logic [15:0]               data1,
  output logic [15:0]               data2
);

  localparam int VEC_N = 1 << DATA1_LEN_BITS;
  localparam int MAT_W = DATA2_ROW_BITS + DATA2_COL_BITS;
  localparam int MAT_N = 1 << MAT_W;
  localparam int CNT_W = (DATA1_LEN_BITS > MAT_W) ? DATA1_LEN_BITS : MAT_W;
  localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(VEC_N - 1);
  localparam logic [CNT_W-1:0] MAT_LAST = CNT_W'(MAT_N - 1);

  typedef enum logic [1:0] {IDLE, LOAD_VEC, LOAD_MAT, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               err_n;
  logic               wr_vec, wr_mat;
  logic [15:0]        vec [VEC_N];
  logic [15:0]        mat [MAT_N];

  // The LOAD state itself records the latched load_target.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    err_n      = 1'b0;
    load_ready = 1'b0;
    load_done  = 1'b0;
    wr_vec     = 1'b0;
    wr_mat     = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          if (lock) begin
            err_n = 1'b1;
          end else begin
            cnt_n   = '0;
            state_n = load_target ? LOAD_MAT : LOAD_VEC;
          end
        end
      end
      LOAD_VEC: begin
        load_ready = !lock;
        err_n      = load_valid && lock;
        if (load_valid && !lock) begin
          wr_vec = 1'b1;
          if (cnt == VEC_LAST) begin
            cnt_n   = '0;
            state_n = DONE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      LOAD_MAT: begin
        load_ready = !lock;
        err_n      = load_valid && lock;
        if (load_valid && !lock) begin
          wr_mat = 1'b1;
          if (cnt == MAT_LAST) begin
            cnt_n   = '0;
            state_n = DONE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Nonblocking reads sample storage before this cycle's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      err_locked <= 1'b0;
      data1      <= '0;
      data2      <= '0;
      for (int i = 0; i < VEC_N; i++) vec[i] <= '0;
      for (int i = 0; i < MAT_N; i++) mat[i] <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      err_locked <= err_n;
      data1      <= vec[sel_vec];
      data2      <= mat[{sel_row, sel_col}];
      if (wr_vec) vec[cnt[DATA1_LEN_BITS-1:0]] <= load_data;
      if (wr_mat) mat[cnt[MAT_W-1:0]] <= load_data;
    end
  end

endmodule

// File: tb/tb_tensor_operand_server.sv
// tb/tb_tensor_operand_server.sv - randomized bench for tensor_operand_server against an array scoreboard
module tb_tensor_operand_server;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock, load_start, load_target, load_valid;
  logic [15:0] load_data;
  logic        load_ready, load_done, err_locked;
  logic [1:0]  sel_vec, sel_row;
  logic [3:0]  sel_col;
  logic [15:0] data1, data2;

  logic [15:0] vec_m [4];
  logic [15:0] mat_m [64];
  logic [15:0] bdata [64];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tensor_operand_server dut (
    .clk(clk), .rst_n(rst_n), .lock(lock), .load_start(load_start),
    .load_target(load_target), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .err_locked(err_locked),
    .sel_vec(sel_vec), .sel_row(sel_row), .sel_col(sel_col),
    .data1(data1), .data2(data2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 4; i++) vec_m[i] = '0;
    for (int i = 0; i < 64; i++) mat_m[i] = '0;
  endtask

  task automatic rd(input logic [1:0] sv, input logic [1:0] r, input logic [3:0] c);
    sel_vec = sv; sel_row = r; sel_col = c;
    load_start = 0; load_valid = 0; lock = 1'($urandom_range(0, 1));
    tick;
    check("rd_vec", data1, vec_m[sv]);
    check("rd_mat", data2, mat_m[{r, c}]);
    lock = 0;
  endtask

  // One host burst; abort_at >= 0 returns early after that many accepted beats.
  task automatic run_burst(input bit tgt, input int gap_every, input int lock_at,
                           input int lock_len, input int abort_at);
    int n = tgt ? 64 : 4;
    int idx = 0;
    int cyc = 0;
    int lock_left = 0;
    bit lock_used = 0;
    bit exp_err = 0;
    bit v, l;
    logic [15:0] exp_d1, exp_d2;
    load_start = 1; load_target = tgt; load_valid = 1; load_data = 16'hAAAA; lock = 0;
    #1 check("idle_ready", load_ready, 0);
    tick;
    load_start = 0; load_valid = 0;
    while (idx < n && cyc < 400) begin
      check("err", err_locked, exp_err);
      if (!lock_used && idx == lock_at) begin
        lock_left = lock_len;
        lock_used = 1;
      end
      l = (lock_left > 0);
      if (l) lock_left--;
      v = l || gap_every == 0 || (cyc % gap_every != gap_every - 1);
      lock = l; load_valid = v;
      load_data = l ? 16'hDEAD : bdata[idx];
      load_start = ($urandom_range(0, 3) == 0);
      load_target = !tgt;
      sel_vec = 2'(idx); sel_row = 2'(idx >> 4); sel_col = 4'(idx);
      exp_d1 = vec_m[sel_vec];
      exp_d2 = mat_m[{sel_row, sel_col}];
      #1;
      check("ready", load_ready, !l);
      check("done_early", load_done, 0);
      if (v && !l) begin
        if (tgt) mat_m[idx] = load_data;
        else vec_m[idx] = load_data;
        idx++;
      end
      exp_err = v && l;
      tick;
      check("rd1_burst", data1, exp_d1);
      check("rd2_burst", data2, exp_d2);
      cyc++;
      if (idx == abort_at) return;
    end
    if (cyc >= 400) check("burst_budget", 0, 1);
    lock = 0; load_valid = 0; load_start = 0;
    check("err_last", err_locked, exp_err);
    check("done", load_done, 1);
    check("done_ready", load_ready, 0);
    tick;
    check("done_clear", load_done, 0);
    check("err_clear", err_locked, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; lock = 0; load_start = 0; load_target = 0; load_valid = 0;
    load_data = '0; sel_vec = '0; sel_row = '0; sel_col = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("rst_ready", load_ready, 0);
    check("rst_done", load_done, 0);
    check("rst_err", err_locked, 0);
    rd(2'd3, 2'd2, 4'd15);
    check("rst_data1", data1, 16'h0000);
    check("rst_data2", data2, 16'h0000);

    bdata[0] = 16'h1111; bdata[1] = 16'h2222; bdata[2] = 16'h3333; bdata[3] = 16'h4444;
    run_burst(0, 0, -1, 0, -1);
    rd(2'd2, 2'd0, 2'd0);
    check("vec2_const", data1, 16'h3333);

    for (int i = 0; i < 64; i++) bdata[i] = 16'h0100 + 16'(i);
    run_burst(1, 3, -1, 0, -1);
    rd(2'd0, 2'd1, 4'd5);
    check("mat_1_5", data2, 16'h0115);
    rd(2'd0, 2'd3, 4'd15);
    check("mat_3_15", data2, 16'h013F);

    for (int i = 0; i < 4; i++) bdata[i] = 16'($urandom);
    run_burst(0, 0, 2, 5, -1);
    for (int i = 0; i < 4; i++) rd(2'(i), 2'($urandom), 4'($urandom));

    lock = 1; load_start = 1; load_target = 0; load_valid = 0;
    tick;
    load_start = 0;
    check("lstart_err", err_locked, 1);
    check("lstart_ready", load_ready, 0);
    tick;
    check("lstart_err_clr", err_locked, 0);
    check("lstart_idle", load_ready, 0);
    lock = 0;
    for (int i = 0; i < 4; i++) bdata[i] = 16'($urandom);
    bdata[1] = 16'hBEEF;
    run_burst(0, 0, -1, 0, -1);
    rd(2'd1, 2'd0, 4'd0);
    check("collide_new", data1, 16'hBEEF);

    for (int i = 0; i < 64; i++) bdata[i] = 16'($urandom);
    run_burst(1, 4, $urandom_range(1, 60), 3, -1);
    repeat (10) rd(2'($urandom), 2'($urandom), 4'($urandom));

    for (int i = 0; i < 4; i++) bdata[i] = 16'($urandom);
    run_burst(0, 0, -1, 0, 2);
    rst_n = 0;
    clear_model();
    #1;
    check("mid_rst_data1", data1, 0);
    check("mid_rst_ready", load_ready, 0);
    tick;
    rst_n = 1;
    load_valid = 1; load_start = 0; lock = 0;
    repeat (3) begin
      #1;
      check("post_rst_done", load_done, 0);
      check("post_rst_ready", load_ready, 0);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 2'($urandom), 4'($urandom));
      check("post_rst_vec", data1, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tensor_operand_server.md
Name: tensor_operand_server

Overview:
- Responder side of the matmul operand-fetch interface. Holds one input vector and one weight matrix in registers.
- Answers the engine's sel_vec/sel_row/sel_col addresses with data1/data2, one cycle later.
- Host side loads the vector or the matrix as an auto-incrementing valid/ready burst.
- Loading is locked out while the engine is busy, so operands never change mid-multiply.

Parameters:
- DATA1_LEN_BITS, 2, log2 of vector length (default 4 entries of 16 bits)
- DATA2_ROW_BITS, 2, log2 of matrix row count (default 4)
- DATA2_COL_BITS, 4, log2 of matrix column count (default 16; matrix is 64 entries at defaults)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- lock  in  1  high while the matmul engine is busy; freezes loading
- load_start  in  1  one-cycle request to begin a load burst
- load_target  in  1  sampled with load_start: 0 = vector, 1 = matrix
- load_valid  in  1  host data valid
- load_data  in  16  host data word
- load_ready  out  1  server accepts a word this cycle
- load_done  out  1  one-cycle pulse after the last word of a burst is written
- err_locked  out  1  one-cycle pulse on a rejected load attempt
- sel_vec  in  DATA1_LEN_BITS  vector read index from engine
- sel_row  in  DATA2_ROW_BITS  matrix row index from engine
- sel_col  in  DATA2_COL_BITS  matrix column index from engine
- data1  out  16  registered vector[sel_vec]
- data2  out  16  registered matrix[sel_row][sel_col]

Behaviour:
- Reset (async, rst_n low):
  - All vector and matrix entries, data1 and data2 go to 0.
  - State goes to IDLE and the beat counter to 0.
  - load_ready, load_done and err_locked go to 0.
  - Reset mid-burst abandons the burst. Entries already written are cleared, because reset clears all storage.
- Read path:
  - Every clock, data1 <= vector[sel_vec] and data2 <= matrix[{sel_row,sel_col}].
  - Latency is 1 cycle; reads are unconditional and ignore lock and FSM state.
  - Same-cycle write and read of the same entry returns the old value (read-before-write). The new value is visible from the next read.
- Matrix storage is row-major: flat index = {row,col}; the burst counter maps its MSBs to row and its LSBs to col.
- FSM states: IDLE, LOAD_VEC, LOAD_MAT, DONE.
- IDLE:
  - load_start=1 and lock=0: latch load_target, clear counter, go to LOAD_VEC (target 0) or LOAD_MAT (target 1).
  - load_start=1 and lock=1: stay in IDLE and pulse err_locked next cycle.
- LOAD_VEC / LOAD_MAT:
  - load_ready = !lock (combinational from state and lock).
  - A beat is accepted when load_valid && load_ready: write load_data to entry[counter], then counter+1.
  - Burst length is 2^DATA1_LEN_BITS words for the vector and 2^(DATA2_ROW_BITS+DATA2_COL_BITS) words for the matrix.
  - Accepting the final beat moves the FSM to DONE. The counter wraps to 0; there is no overflow write.
  - load_valid=0: hold state; counter unchanged.
  - lock rising mid-burst: load_ready drops the same cycle and no write occurs. The burst pauses with counter preserved and resumes when lock falls.
  - load_valid=1 while lock=1: no write; pulse err_locked next cycle, once per offending cycle.
  - load_start while in a LOAD state is ignored and does not restart the burst.
- DONE: load_done=1 for exactly this one cycle, load_ready=0, then return to IDLE unconditionally.
- The earliest new load_start is accepted in the IDLE cycle after DONE.
- load_start and load_valid asserted in the same IDLE cycle: only the start is taken. The first beat can be accepted in the following cycle at the earliest.
- err_locked and load_done are registered single-cycle pulses, 0 otherwise.
- Storage is only written in LOAD states; the engine has no write path.

Test Plan:
- Reset then read: rst_n low 2 cycles, release; sel_vec=3, sel_row=2, sel_col=15 -> data1=0x0000, data2=0x0000 one cycle later; load_ready=0; no load_done or err_locked pulse.
- Vector load: load_start with target=0, then 4 back-to-back beats 0x1111, 0x2222, 0x3333, 0x4444 -> load_ready high 4 cycles, load_done pulses the cycle after beat 4; sel_vec=2 -> data1=0x3333 one cycle later.
- Matrix load with gaps: target=1, 64 beats of value {row,col}+0x0100 with load_valid deasserted every 3rd cycle -> load_done after the 64th accepted beat; sel_row=1, sel_col=5 -> data2=0x0115; sel_row=3, sel_col=15 -> data2=0x013F.
- Lock mid-burst:
  - Stimulus: during a vector load, raise lock after beat 2 for 5 cycles with load_valid held at 1 and data 0xDEAD.
  - Required: load_ready=0 and err_locked pulses 5 times; vector[2] unchanged.
  - After lock falls, beats 3–4 are written and load_done pulses.
- Locked start: lock=1, load_start -> err_locked one pulse, FSM stays IDLE, load_ready stays 0; repeat with lock=0 -> burst starts.
- Read/write collision and reset mid-burst:
  - Collision: write 0xBEEF to vector[1] while sel_vec=1 -> data1 shows the old value, then 0xBEEF on the next cycle.
  - Reset mid-burst: assert rst_n after 2 of 4 beats -> vector all 0, FSM IDLE, load_done never pulses.
